// File: rtl/control_unit_pkg.sv
// Shared encodings for the accumulator machine: opcodes, ALU operation
// codes, bus source codes and the control FSM state set.
package control_unit_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MVAC  = 4'h1;
  localparam logic [3:0] OP_MVR   = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_INCR  = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_OR    = 4'hA;
  localparam logic [3:0] OP_JMPZ  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_LDI   = 4'hD;
  localparam logic [3:0] OP_ILL   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_INCR = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SHL  = 4'b0011;
  localparam logic [3:0] ALU_SHR  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NONE = 4'b0111;

  // Bus sources 0..7 select R[n] directly.
  localparam logic [3:0] BUS_AC   = 4'd0;
  localparam logic [3:0] BUS_DRAM = 4'd8;
  localparam logic [3:0] BUS_OPND = 4'd9;
  localparam logic [3:0] BUS_ALU  = 4'd10;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH1, ST_FETCH2, ST_DECODE, ST_OPF1, ST_OPF2,
    ST_EXEC1, ST_EXEC2, ST_MEM1, ST_MEM2, ST_HALT
  } state_t;

  // Opcodes that run through the ALU and write the result back to AC.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  // ALU operation applied for an arithmetic/logic opcode.
  function automatic logic [3:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_INCR: return ALU_INCR;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      OP_OR:   return ALU_OR;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit to datapath/memory signal bundle. The master side is the
// control unit; the slave side is the datapath plus instruction memory.
interface control_unit_if #(parameter int NREG = 8);
  import control_unit_pkg::*;

  logic            start;
  logic [7:0]      instr_in;
  logic            zero_flag;
  logic            iram_rd;
  logic            pc_inc;
  logic            pc_load;
  logic [7:0]      pc_target;
  logic [7:0]      operand_out;
  logic [3:0]      alu_sel;
  logic [3:0]      bus_sel;
  logic [NREG-1:0] reg_load;
  logic            dram_rd;
  logic            dram_wr;
  logic            done;
  logic            illegal;

  modport master (
    input  start, instr_in, zero_flag,
    output iram_rd, pc_inc, pc_load, pc_target, operand_out, alu_sel,
           bus_sel, reg_load, dram_rd, dram_wr, done, illegal
  );

  modport slave (
    output start, instr_in, zero_flag,
    input  iram_rd, pc_inc, pc_load, pc_target, operand_out, alu_sel,
           bus_sel, reg_load, dram_rd, dram_wr, done, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the accumulator machine. Next state and the
// outputs belonging to that next state are decoded combinationally and then
// registered together, so every output is a flop and is cleared by reset.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.master bus
);

  localparam logic [NREG-1:0] LOAD_AC = {{(NREG-1){1'b0}}, 1'b1};

  // Register fields wrap modulo the register count.
  function automatic logic [3:0] wrap_reg(input logic [3:0] r);
    return 4'(int'(r) % NREG);
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      opnd_q, opnd_d;
  logic            zflag_q, zflag_d;

  logic            iram_rd_q, iram_rd_d;
  logic            pc_inc_q, pc_inc_d;
  logic            pc_load_q, pc_load_d;
  logic [7:0]      pc_target_q, pc_target_d;
  logic [7:0]      operand_out_q, operand_out_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic [3:0]      bus_sel_q, bus_sel_d;
  logic [NREG-1:0] reg_load_q, reg_load_d;
  logic            dram_rd_q, dram_rd_d;
  logic            dram_wr_q, dram_wr_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      op_d;
  logic [3:0]      r_d;

  // Next-state sequencing and capture of IR, operand byte and zero flag.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    zflag_d = zflag_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_FETCH1;
      ST_FETCH1: state_d = ST_FETCH2;
      ST_FETCH2: begin
        ir_d    = bus.instr_in;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (ir_q[7:4])
          OP_JMPZ, OP_JMP, OP_LDI: state_d = ST_OPF1;
          OP_LOAD, OP_STORE:       state_d = ST_MEM1;
          OP_HALT:                 state_d = ST_HALT;
          OP_NOP, OP_ILL:          state_d = ST_FETCH1;
          default:                 state_d = ST_EXEC1;
        endcase
      end
      ST_OPF1:   state_d = ST_OPF2;
      ST_OPF2: begin
        opnd_d  = bus.instr_in;
        state_d = ST_EXEC1;
      end
      ST_EXEC1:  state_d = is_alu_op(ir_q[7:4]) ? ST_EXEC2 : ST_FETCH1;
      ST_EXEC2: begin
        // zero_flag reflects the op applied during EXEC1.
        zflag_d = bus.zero_flag;
        state_d = ST_FETCH1;
      end
      ST_MEM1:   state_d = (ir_q[7:4] == OP_LOAD) ? ST_MEM2 : ST_FETCH1;
      ST_MEM2:   state_d = ST_FETCH1;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode for the state being entered; uses the freshly captured IR/operand.
  always_comb begin
    op_d          = ir_d[7:4];
    r_d           = wrap_reg(ir_d[3:0]);
    iram_rd_d     = 1'b0;
    pc_inc_d      = 1'b0;
    pc_load_d     = 1'b0;
    pc_target_d   = '0;
    operand_out_d = '0;
    alu_sel_d     = ALU_NONE;
    bus_sel_d     = BUS_AC;
    reg_load_d    = '0;
    dram_rd_d     = 1'b0;
    dram_wr_d     = 1'b0;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    case (state_d)
      ST_FETCH1, ST_OPF1: iram_rd_d = 1'b1;
      ST_FETCH2, ST_OPF2: pc_inc_d  = 1'b1;
      ST_DECODE:          illegal_d = (op_d == OP_ILL);
      ST_EXEC1: begin
        case (op_d)
          OP_MVAC: begin
            bus_sel_d  = r_d;
            reg_load_d = LOAD_AC;
          end
          OP_MVR:  reg_load_d = LOAD_AC << r_d;
          OP_LDI: begin
            bus_sel_d     = BUS_OPND;
            reg_load_d    = LOAD_AC;
            operand_out_d = opnd_d;
          end
          OP_JMP: begin
            pc_load_d   = 1'b1;
            pc_target_d = opnd_d;
          end
          OP_JMPZ: begin
            // Branch on the latched flag of the last ALU op, not the live input.
            pc_load_d   = zflag_d;
            pc_target_d = opnd_d;
          end
          default: begin
            if (is_alu_op(op_d)) begin
              bus_sel_d = r_d;
              alu_sel_d = alu_code(op_d);
            end
          end
        endcase
      end
      ST_EXEC2: begin
        bus_sel_d  = BUS_ALU;
        reg_load_d = LOAD_AC;
      end
      ST_MEM1: begin
        if (op_d == OP_LOAD) dram_rd_d = 1'b1;
        else                 dram_wr_d = 1'b1;
      end
      ST_MEM2: begin
        bus_sel_d  = BUS_DRAM;
        reg_load_d = LOAD_AC;
      end
      ST_HALT:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State, internal registers and registered outputs; reset clears all at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ir_q          <= '0;
      opnd_q        <= '0;
      zflag_q       <= 1'b0;
      iram_rd_q     <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_target_q   <= '0;
      operand_out_q <= '0;
      alu_sel_q     <= ALU_NONE;
      bus_sel_q     <= BUS_AC;
      reg_load_q    <= '0;
      dram_rd_q     <= 1'b0;
      dram_wr_q     <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      opnd_q        <= opnd_d;
      zflag_q       <= zflag_d;
      iram_rd_q     <= iram_rd_d;
      pc_inc_q      <= pc_inc_d;
      pc_load_q     <= pc_load_d;
      pc_target_q   <= pc_target_d;
      operand_out_q <= operand_out_d;
      alu_sel_q     <= alu_sel_d;
      bus_sel_q     <= bus_sel_d;
      reg_load_q    <= reg_load_d;
      dram_rd_q     <= dram_rd_d;
      dram_wr_q     <= dram_wr_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.iram_rd     = iram_rd_q;
  assign bus.pc_inc      = pc_inc_q;
  assign bus.pc_load     = pc_load_q;
  assign bus.pc_target   = pc_target_q;
  assign bus.operand_out = operand_out_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.bus_sel     = bus_sel_q;
  assign bus.reg_load    = reg_load_q;
  assign bus.dram_rd     = dram_rd_q;
  assign bus.dram_wr     = dram_wr_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instruction sequences cycle by
// cycle and compares the full output vector against hand-derived values.
module tb_control_unit;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  control_unit_if #(.NREG(8)) cif ();

  control_unit #(.NREG(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bit order: {iram_rd, pc_inc, pc_load, dram_rd, dram_wr, done, illegal}
  localparam logic [6:0] C_NO   = 7'b0000000;
  localparam logic [6:0] C_IRD  = 7'b1000000;
  localparam logic [6:0] C_INC  = 7'b0100000;
  localparam logic [6:0] C_PCL  = 7'b0010000;
  localparam logic [6:0] C_DRD  = 7'b0001000;
  localparam logic [6:0] C_DWR  = 7'b0000100;
  localparam logic [6:0] C_DONE = 7'b0000010;
  localparam logic [6:0] C_ILL  = 7'b0000001;
  localparam logic [3:0] AN     = 4'b0111;

  function automatic logic [38:0] ex(input logic [6:0] ctl, input logic [3:0] alu,
                                     input logic [3:0] bsel, input logic [7:0] rl,
                                     input logic [7:0] tgt, input logic [7:0] opd);
    return {ctl, alu, bsel, rl, tgt, opd};
  endfunction

  function automatic logic [38:0] obs();
    return {cif.iram_rd, cif.pc_inc, cif.pc_load, cif.dram_rd, cif.dram_wr,
            cif.done, cif.illegal, cif.alu_sel, cif.bus_sel, cif.reg_load,
            cif.pc_target, cif.operand_out};
  endfunction

  task automatic check_eq(input string tag, input logic [38:0] got, input logic [38:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [38:0] exp);
    @(negedge clk);
    check_eq(tag, obs(), exp);
  endtask

  logic [38:0] idle_x, f1_x, f2_x;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_x = ex(C_NO, AN, 4'd0, 8'h00, 8'h00, 8'h00);
    f1_x   = ex(C_IRD, AN, 4'd0, 8'h00, 8'h00, 8'h00);
    f2_x   = ex(C_INC, AN, 4'd0, 8'h00, 8'h00, 8'h00);
    rst = 1'b0; cif.start = 1'b0; cif.instr_in = 8'h00; cif.zero_flag = 1'b0;
    #1 rst = 1'b1;
    #1 check_eq("reset_async", obs(), idle_x);
    @(negedge clk); rst = 1'b0;
    step("idle_no_start", idle_x);
    cif.start = 1'b1;

    // ADD R3: 5 cycles FETCH1..EXEC2
    step("add.f1", f1_x); cif.start = 1'b0; cif.instr_in = 8'h53;
    step("add.f2", f2_x);
    step("add.dec", idle_x);
    step("add.ex1", ex(C_NO, 4'b0001, 4'd3, 8'h00, 8'h00, 8'h00));
    step("add.ex2", ex(C_NO, AN, 4'd10, 8'h01, 8'h00, 8'h00));

    // SUB R2 producing zero
    step("sub.f1", f1_x); cif.instr_in = 8'h62; cif.zero_flag = 1'b1;
    step("sub.f2", f2_x);
    step("sub.dec", idle_x);
    step("sub.ex1", ex(C_NO, 4'b0010, 4'd2, 8'h00, 8'h00, 8'h00));
    step("sub.ex2", ex(C_NO, AN, 4'd10, 8'h01, 8'h00, 8'h00));

    // NOP: FETCH1, FETCH2, DECODE then back to FETCH1
    step("nop.f1", f1_x); cif.instr_in = 8'h00; cif.zero_flag = 1'b0;
    step("nop.f2", f2_x);
    step("nop.dec", idle_x);

    // JMPZ 0x2A with latched zflag=1, live zero_flag=0
    step("jz1.f1", f1_x); cif.instr_in = 8'hB0;
    step("jz1.f2", f2_x);
    step("jz1.dec", idle_x);
    step("jz1.opf1", f1_x); cif.instr_in = 8'h2A;
    step("jz1.opf2", f2_x);
    step("jz1.ex1", ex(C_PCL, AN, 4'd0, 8'h00, 8'h2A, 8'h00));

    // INCR with zero_flag=0
    step("incr.f1", f1_x); cif.instr_in = 8'h70;
    step("incr.f2", f2_x);
    step("incr.dec", idle_x);
    step("incr.ex1", ex(C_NO, 4'b0000, 4'd0, 8'h00, 8'h00, 8'h00));
    step("incr.ex2", ex(C_NO, AN, 4'd10, 8'h01, 8'h00, 8'h00));

    // JMPZ 0x11 with latched zflag=0 and live zero_flag=1: not taken
    step("jz2.f1", f1_x); cif.instr_in = 8'hB0; cif.zero_flag = 1'b1;
    step("jz2.f2", f2_x);
    step("jz2.dec", idle_x);
    step("jz2.opf1", f1_x); cif.instr_in = 8'h11;
    step("jz2.opf2", f2_x);
    step("jz2.ex1", ex(C_NO, AN, 4'd0, 8'h00, 8'h11, 8'h00));

    // LOAD
    step("load.f1", f1_x); cif.instr_in = 8'h30; cif.zero_flag = 1'b0;
    step("load.f2", f2_x);
    step("load.dec", idle_x);
    step("load.mem1", ex(C_DRD, AN, 4'd0, 8'h00, 8'h00, 8'h00));
    step("load.mem2", ex(C_NO, AN, 4'd8, 8'h01, 8'h00, 8'h00));

    // STORE: dram_wr for exactly one cycle
    step("store.f1", f1_x); cif.instr_in = 8'h40;
    step("store.f2", f2_x);
    step("store.dec", idle_x);
    step("store.mem1", ex(C_DWR, AN, 4'd0, 8'h00, 8'h00, 8'h00));

    // LDI 0x7F: 6 cycles, two pc_inc pulses
    step("ldi.f1", f1_x); cif.instr_in = 8'hD0;
    step("ldi.f2", f2_x);
    step("ldi.dec", idle_x);
    step("ldi.opf1", f1_x); cif.instr_in = 8'h7F;
    step("ldi.opf2", f2_x);
    step("ldi.ex1", ex(C_NO, AN, 4'd9, 8'h01, 8'h00, 8'h7F));

    // MVR R5
    step("mvr.f1", f1_x); cif.instr_in = 8'h25;
    step("mvr.f2", f2_x);
    step("mvr.dec", idle_x);
    step("mvr.ex1", ex(C_NO, AN, 4'd0, 8'h20, 8'h00, 8'h00));

    // MVAC R9 wraps to R1
    step("mvac.f1", f1_x); cif.instr_in = 8'h19;
    step("mvac.f2", f2_x);
    step("mvac.dec", idle_x);
    step("mvac.ex1", ex(C_NO, AN, 4'd1, 8'h01, 8'h00, 8'h00));

    // JMP 0x55
    step("jmp.f1", f1_x); cif.instr_in = 8'hC0;
    step("jmp.f2", f2_x);
    step("jmp.dec", idle_x);
    step("jmp.opf1", f1_x); cif.instr_in = 8'h55;
    step("jmp.opf2", f2_x);
    step("jmp.ex1", ex(C_PCL, AN, 4'd0, 8'h00, 8'h55, 8'h00));

    // Illegal 0xE5: one-cycle pulse, no register loads
    step("ill.f1", f1_x); cif.instr_in = 8'hE5;
    step("ill.f2", f2_x);
    step("ill.dec", ex(C_ILL, AN, 4'd0, 8'h00, 8'h00, 8'h00));

    // ADD R1 interrupted by reset in EXEC1
    step("add2.f1", f1_x); cif.instr_in = 8'h51;
    step("add2.f2", f2_x);
    step("add2.dec", idle_x);
    step("add2.ex1", ex(C_NO, 4'b0001, 4'd1, 8'h00, 8'h00, 8'h00));
    #1 rst = 1'b1;
    #1 check_eq("rst_mid_ex1", obs(), idle_x);
    @(negedge clk); rst = 1'b0;
    step("idle_after_rst", idle_x);
    step("idle_after_rst2", idle_x);
    cif.start = 1'b1;

    // HALT: done held, start ignored
    step("halt.f1", f1_x); cif.start = 1'b0; cif.instr_in = 8'hF0;
    step("halt.f2", f2_x);
    step("halt.dec", idle_x);
    step("halt.done", ex(C_DONE, AN, 4'd0, 8'h00, 8'h00, 8'h00));
    cif.start = 1'b1;
    step("halt.start_ign", ex(C_DONE, AN, 4'd0, 8'h00, 8'h00, 8'h00));
    cif.start = 1'b0;
    step("halt.hold", ex(C_DONE, AN, 4'd0, 8'h00, 8'h00, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter NREG, default 8: number of registers on the shared bus; R0 = AC, R1 = AR.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  begins execution from IDLE.
REQ-005 instr_in  in  8  instruction-memory read data, valid the cycle after iram_rd.
REQ-006 zero_flag  in  1  ALU zero flag, valid the cycle after alu_sel is applied.
REQ-007 iram_rd  out  1  instruction-memory read strobe.
REQ-008 pc_inc, pc_load  out  1 each  program-counter increment and load.
REQ-009 pc_target, operand_out  out  8 each  the operand byte, zero-extended onto the bus by the datapath.
REQ-010 alu_sel  out  4  ALU operation: INCR 0000, ADD 0001, SUB 0010, SHL 0011, SHR 0100, OR 0101, NONE 0111.
REQ-011 bus_sel  out  4  bus source: 0..7 = R[n], 8 = DRAM data, 9 = operand, 10 = ALU result.
REQ-012 reg_load  out  NREG  one-hot register load enable.
REQ-013 dram_rd, dram_wr  out  1 each  data-memory strobes; address is AR.
REQ-014 done, illegal  out  1 each  halted status and one-cycle illegal-opcode pulse.

Function
REQ-015 Instruction byte: op = [7:4], r = [3:0] (values >= NREG wrap modulo NREG).
REQ-016 Opcodes:
- 0 NOP; 1 MVAC (AC<-R[r]); 2 MVR (R[r]<-AC); 3 LOAD; 4 STORE.
- 5 ADD, 6 SUB, 7 INCR (AC only), 8 SHL, 9 SHR, A OR, all AC <- AC op R[r].
- B JMPZ, C JMP, D LDI: each takes a second operand byte.
- F HALT; E illegal.
REQ-017 States: IDLE, FETCH1, FETCH2, DECODE, OPF1, OPF2, EXEC1, EXEC2, MEM1, MEM2, HALT.
REQ-018 All outputs are zero in every state except as listed; alu_sel is 0111 outside EXEC1.
REQ-019 IDLE: start=1 -> FETCH1; otherwise remain.
REQ-020 FETCH1: iram_rd=1.
REQ-021 FETCH2: internal IR <- instr_in; pc_inc=1.
REQ-022 DECODE: B/C/D -> OPF1; 3/4 -> MEM1; F -> HALT; 0 -> FETCH1; E -> illegal=1, then FETCH1; others -> EXEC1.
REQ-023 OPF1: iram_rd=1. OPF2: operand register <- instr_in; pc_inc=1; -> EXEC1.
REQ-024 ALU ops, EXEC1: bus_sel=r, alu_sel per REQ-010. EXEC2: bus_sel=10, reg_load[0]=1, internal zflag <- zero_flag; -> FETCH1.
REQ-025 ALU instruction latency is 5 cycles from FETCH1 to the next FETCH1.
REQ-026 MVAC, EXEC1: bus_sel=r, reg_load[0]=1.
REQ-027 MVR, EXEC1: bus_sel=0, reg_load[r]=1.
REQ-028 LDI, EXEC1: bus_sel=9, reg_load[0]=1.
REQ-029 MVAC, MVR and LDI each go to FETCH1 after EXEC1.
REQ-030 JMP, EXEC1: pc_load=1. JMPZ, EXEC1: pc_load=zflag, the flag latched by the most recent ALU op, not the live input.
REQ-031 LOAD: MEM1 dram_rd=1; MEM2 bus_sel=8, reg_load[0]=1; then FETCH1.
REQ-032 STORE: MEM1 bus_sel=0, dram_wr=1; then FETCH1.
REQ-033 HALT: done=1; remain until rst; start is ignored.
REQ-034 start outside IDLE is ignored.
REQ-035 pc_inc and pc_load are never asserted in the same cycle.
REQ-036 At most one reg_load bit is set in any cycle.

Reset
REQ-037 On rst: state IDLE; IR, operand register and zflag cleared; all outputs per REQ-018 immediately, with no clock edge required.
REQ-038 Reset mid-instruction abandons that instruction with no further strobes.
REQ-039 The first rising edge after rst deasserts evaluates the IDLE rules.

Structure
REQ-040 A shared package, also used by alu, shall hold the opcode constants, ALU_SEL codes, bus_sel codes and the state enumeration.
REQ-041 No sub-module; the next-state and output decode live in control_unit.

Verification
REQ-042 rst=1 mid-EXEC1 of ADD -> all outputs 0 and alu_sel=0111 within the same cycle; IDLE after release.
REQ-043 start, instr 0x53, zero_flag=0 -> FETCH1..EXEC2 = 5 cycles; alu_sel=0001 and bus_sel=3 in EXEC1; reg_load=0x01 in EXEC2.
REQ-044 SUB giving zero_flag=1, then NOP, then JMPZ 0x2A -> pc_load=1 with pc_target=0x2A; after INCR with zero_flag=0, JMPZ -> pc_load=0.
REQ-045 LOAD (0x30) then STORE (0x40) -> dram_rd in MEM1 and bus_sel=8 in MEM2; dram_wr=1 with bus_sel=0 for exactly one cycle.
REQ-046 Opcode 0xE5 -> illegal pulses for one cycle and no register loads; 0xF0 -> done held; a start pulse is ignored.
REQ-047 LDI 0x7F -> operand_out=0x7F, bus_sel=9, reg_load=0x01; instruction takes 6 cycles and pc_inc pulses twice.
